fifo_read_serializer: RTL and testbench

Read-side stage that sits directly downstream of the synchronous circular FIFO. It pops wide FIFO words, holds one word in flight plus one prefetched word, and serializes each word into narrower beats on a valid/ready output stream, LSB slice first. The two word slots and the prefetch hide the FIFO's 1-cycle read latency, so back-to-back words stream without bubbles.

---
 rtl/fifo_read_serializer.sv | 132 +++++++++++++
 tb/tb_fifo_read_serializer.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_read_serializer.sv
// fifo_read_serializer
//
// Read-side stage placed directly after a synchronous FIFO that has a 1-cycle
// read latency. It pops wide FIFO words, keeps one word being serialized plus
// one prefetched word, and sends each word out as RATIO narrower beats on a
// valid/ready stream, lowest slice first. Because of the prefetch slot,
// back-to-back words stream with no idle cycles between them.
//
// Parameters
//   IN_WIDTH   FIFO word width (an integer multiple of OUT_WIDTH)
//   OUT_WIDTH  output beat width (IN_WIDTH/OUT_WIDTH must be >= 2)
//   CNT_WIDTH  width of the wrapping completed-word counter
//
// Ports
//   clk_i         clock; all state changes on the rising edge
//   rst_i         synchronous active-high reset
//   fifo_data_i   FIFO read data, valid in the cycle after a pop
//   fifo_empty_i  FIFO empty flag
//   fifo_rd_en_o  FIFO pop request
//   m_data_o      current output beat
//   m_valid_o     beat valid
//   m_ready_i     downstream ready
//   m_last_o      final beat of the current word
//   word_count_o  number of fully emitted words (wraps)
module fifo_read_serializer #(
  parameter int IN_WIDTH  = 64,
  parameter int OUT_WIDTH = 16,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [IN_WIDTH-1:0]  fifo_data_i,
  input  logic                 fifo_empty_i,
  output logic                 fifo_rd_en_o,
  output logic [OUT_WIDTH-1:0] m_data_o,
  output logic                 m_valid_o,
  input  logic                 m_ready_i,
  output logic                 m_last_o,
  output logic [CNT_WIDTH-1:0] word_count_o
);

  localparam int RATIO = IN_WIDTH / OUT_WIDTH;
  localparam int IDX_W = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RATIO - 1);

  logic [IN_WIDTH-1:0]  cur_word;
  logic [IN_WIDTH-1:0]  next_word;
  logic                 cur_valid;
  logic                 next_valid;
  logic                 rd_pending;
  logic [IDX_W-1:0]     beat_idx;
  logic [CNT_WIDTH-1:0] word_count;

  logic [1:0]           occupancy;
  logic                 beat_fire;
  logic                 release_cur;
  logic [RATIO-1:0][OUT_WIDTH-1:0] cur_slices;

  // Occupancy counts every word we own or have already asked for: the word
  // being serialized, the prefetched word, and a read whose data arrives this
  // cycle. Popping only below two guarantees an arriving word always has a
  // free slot, and reset blocks pops so nothing new is requested during it.
  always_comb begin
    occupancy    = {1'b0, cur_valid} + {1'b0, next_valid} + {1'b0, rd_pending};
    fifo_rd_en_o = !rst_i && !fifo_empty_i && (occupancy < 2'd2);
  end

  // The output is a pure view of the current word. Reshaping the word into a
  // packed array of beats lets beat_idx select the slice directly, lowest
  // slice first. release_cur marks the acceptance of the final beat.
  always_comb begin
    cur_slices  = cur_word;
    m_data_o    = cur_slices[beat_idx];
    m_valid_o   = cur_valid;
    m_last_o    = cur_valid && (beat_idx == LAST_IDX);
    beat_fire   = cur_valid && m_ready_i;
    release_cur = beat_fire && (beat_idx == LAST_IDX);
  end

  assign word_count_o = word_count;

  // Slot management. A word arriving from the FIFO lands in cur when cur is
  // free (or is being released with nothing prefetched), otherwise in next.
  // When cur is released the prefetched word moves up, and an arriving word
  // refills whichever slot becomes free, so a word is never dropped or
  // reordered. A read in flight during reset is simply not captured.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cur_word   <= '0;
      next_word  <= '0;
      cur_valid  <= 1'b0;
      next_valid <= 1'b0;
      rd_pending <= 1'b0;
      beat_idx   <= '0;
      word_count <= '0;
    end else begin
      rd_pending <= fifo_rd_en_o;

      if (beat_fire) begin
        beat_idx <= release_cur ? '0 : beat_idx + IDX_W'(1);
      end

      if (release_cur) begin
        word_count <= word_count + CNT_WIDTH'(1);
      end

      if (release_cur) begin
        if (next_valid) begin
          cur_word <= next_word;
          if (rd_pending) begin
            next_word <= fifo_data_i;
          end else begin
            next_valid <= 1'b0;
          end
        end else if (rd_pending) begin
          cur_word <= fifo_data_i;
        end else begin
          cur_valid <= 1'b0;
        end
      end else if (rd_pending) begin
        if (!cur_valid && !next_valid) begin
          cur_word  <= fifo_data_i;
          cur_valid <= 1'b1;
        end else begin
          next_word  <= fifo_data_i;
          next_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_fifo_read_serializer.sv
// tb_fifo_read_serializer
//
// Self-checking bench for fifo_read_serializer (64-bit words, 16-bit beats,
// 4-bit word counter). A queue acts as the upstream FIFO with one cycle of
// read latency. The reference model tracks words by count: how many were
// popped, how many have had their data delivered, and how many are fully
// emitted, plus a queue of the beats still expected, in pop order.
module tb_fifo_read_serializer;

  localparam int IN_W  = 64;
  localparam int OUT_W = 16;
  localparam int CNT_W = 4;
  localparam int RATIO = IN_W / OUT_W;

  logic             clk_i = 1'b0;
  logic             rst_i;
  logic [IN_W-1:0]  fifo_data_i;
  logic             fifo_empty_i;
  logic             fifo_rd_en_o;
  logic [OUT_W-1:0] m_data_o;
  logic             m_valid_o;
  logic             m_ready_i;
  logic             m_last_o;
  logic [CNT_W-1:0] word_count_o;

  fifo_read_serializer #(
    .IN_WIDTH (IN_W),
    .OUT_WIDTH(OUT_W),
    .CNT_WIDTH(CNT_W)
  ) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .fifo_data_i (fifo_data_i),
    .fifo_empty_i(fifo_empty_i),
    .fifo_rd_en_o(fifo_rd_en_o),
    .m_data_o    (m_data_o),
    .m_valid_o   (m_valid_o),
    .m_ready_i   (m_ready_i),
    .m_last_o    (m_last_o),
    .word_count_o(word_count_o)
  );

  always #5 clk_i = ~clk_i;

  // Upstream FIFO contents and reference model state
  logic [IN_W-1:0]  fifo_q[$];
  logic [OUT_W-1:0] beat_q[$];
  logic             force_empty = 1'b0;
  int               pops_total = 0;
  int               pop_last = 0;
  int               words_done = 0;
  int               beat_in_word = 0;

  logic             exp_rd_en, exp_valid, exp_last;
  logic [OUT_W-1:0] exp_data;
  logic [CNT_W-1:0] exp_count;
  logic             obs_rd_en, obs_valid, obs_last;
  logic [OUT_W-1:0] obs_data;
  logic [CNT_W-1:0] obs_count;

  int passed = 0;
  int total  = 0;

  // One clock cycle. Called just after a falling edge with the inputs for the
  // cycle already driven. Computes the expected outputs from the model, samples
  // the DUT, then advances through the rising edge and updates the model and
  // the FIFO (whose read data appears in the following cycle).
  task automatic tick();
    int avail;
    logic [IN_W-1:0]  w;
    logic [OUT_W-1:0] dummy;
    fifo_empty_i = force_empty || (fifo_q.size() == 0);
    #1;
    // words whose data has reached the DUT and are not yet fully emitted
    avail     = pops_total - pop_last - words_done;
    exp_rd_en = !rst_i && !fifo_empty_i && ((avail + pop_last) < 2);
    exp_valid = (avail > 0);
    exp_data  = (exp_valid && beat_q.size() > 0) ? beat_q[0] : '0;
    exp_last  = exp_valid && (beat_in_word == RATIO - 1);
    exp_count = CNT_W'(words_done);
    obs_rd_en = fifo_rd_en_o;
    obs_valid = m_valid_o;
    obs_last  = m_last_o;
    obs_data  = m_data_o;
    obs_count = word_count_o;
    @(posedge clk_i);
    if (rst_i) begin
      fifo_q.delete();
      beat_q.delete();
      pops_total   = 0;
      pop_last     = 0;
      words_done   = 0;
      beat_in_word = 0;
      #1;
      fifo_data_i = {$urandom, $urandom};
    end else begin
      if (exp_valid && m_ready_i) begin
        if (beat_q.size() > 0) dummy = beat_q.pop_front();
        if (beat_in_word == RATIO - 1) begin
          beat_in_word = 0;
          words_done++;
        end else begin
          beat_in_word++;
        end
      end
      if (obs_rd_en && fifo_q.size() > 0) begin
        w = fifo_q.pop_front();
        for (int i = 0; i < RATIO; i++) beat_q.push_back(w[i*OUT_W +: OUT_W]);
        pops_total++;
        pop_last = 1;
        #1;
        fifo_data_i = w;
      end else begin
        pop_last = 0;
        #1;
        fifo_data_i = {$urandom, $urandom};
      end
    end
    @(negedge clk_i);
  endtask

  task automatic test_reset();
    logic [OUT_W-1:0] dummy;
    int hs;
    // power-on reset
    rst_i = 1'b1;
    m_ready_i = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      total++; if (obs_rd_en !== 1'b0) $display("[TB] FAIL por_rd_en: got %b want 0", obs_rd_en); else passed++;
    end
    total++; if (obs_valid !== 1'b0) $display("[TB] FAIL por_valid: got %b want 0", obs_valid); else passed++;
    total++; if (obs_count !== '0) $display("[TB] FAIL por_count: got %0d want 0", obs_count); else passed++;
    rst_i = 1'b0;
    // reset in the middle of a word
    fifo_q.push_back({$urandom, $urandom});
    fifo_q.push_back({$urandom, $urandom});
    hs = 0;
    for (int c = 0; c < 12 && hs < 2; c++) begin
      tick();
      if (obs_valid && m_ready_i) hs++;
    end
    total++; if (hs !== 2) $display("[TB] FAIL rst_pre_beats: got %0d want 2", hs); else passed++;
    rst_i = 1'b1;
    tick();
    total++; if (obs_rd_en !== 1'b0) $display("[TB] FAIL rst_rd_en0: got %b want 0", obs_rd_en); else passed++;
    tick();
    total++; if (obs_rd_en !== 1'b0) $display("[TB] FAIL rst_rd_en1: got %b want 0", obs_rd_en); else passed++;
    total++; if (obs_valid !== 1'b0) $display("[TB] FAIL rst_valid: got %b want 0", obs_valid); else passed++;
    total++; if (obs_last !== 1'b0) $display("[TB] FAIL rst_last: got %b want 0", obs_last); else passed++;
    total++; if (obs_data !== '0) $display("[TB] FAIL rst_data: got %h want 0", obs_data); else passed++;
    total++; if (obs_count !== '0) $display("[TB] FAIL rst_count: got %0d want 0", obs_count); else passed++;
    rst_i = 1'b0;
    for (int c = 0; c < 8; c++) begin
      tick();
      total++; if (obs_valid !== 1'b0) $display("[TB] FAIL rst_stale_valid: got %b want 0", obs_valid); else passed++;
      total++; if (obs_rd_en !== exp_rd_en) $display("[TB] FAIL rst_after_rd_en: got %b want %b", obs_rd_en, exp_rd_en); else passed++;
    end
    dummy = '0;
  endtask

  task automatic test_single_word();
    logic [OUT_W-1:0] want[4];
    int rd_cyc, rd_at, first_valid, nbeats, start;
    want[0] = 16'h6677; want[1] = 16'h4455; want[2] = 16'h2233; want[3] = 16'h0011;
    start = words_done;
    rd_cyc = 0; rd_at = -1; first_valid = -1; nbeats = 0;
    m_ready_i = 1'b1;
    fifo_q.push_back(64'h0011_2233_4455_6677);
    for (int c = 0; c < 10; c++) begin
      tick();
      total++; if (obs_rd_en !== exp_rd_en) $display("[TB] FAIL single_rd_en: got %b want %b", obs_rd_en, exp_rd_en); else passed++;
      total++; if (obs_valid !== exp_valid) $display("[TB] FAIL single_valid: got %b want %b", obs_valid, exp_valid); else passed++;
      if (obs_rd_en) begin rd_cyc++; rd_at = c; end
      if (obs_valid && first_valid < 0) first_valid = c;
      if (obs_valid && m_ready_i) begin
        if (nbeats < 4) begin
          total++; if (obs_data !== want[nbeats]) $display("[TB] FAIL single_data%0d: got %h want %h", nbeats, obs_data, want[nbeats]); else passed++;
        end
        total++; if (obs_last !== (nbeats == 3)) $display("[TB] FAIL single_last%0d: got %b want %b", nbeats, obs_last, nbeats == 3); else passed++;
        nbeats++;
      end
    end
    total++; if (rd_cyc !== 1) $display("[TB] FAIL single_pops: got %0d want 1", rd_cyc); else passed++;
    total++; if (rd_at !== 0) $display("[TB] FAIL single_pop_cycle: got %0d want 0", rd_at); else passed++;
    total++; if (first_valid !== 2) $display("[TB] FAIL single_latency: got %0d want 2", first_valid); else passed++;
    total++; if (nbeats !== 4) $display("[TB] FAIL single_beats: got %0d want 4", nbeats); else passed++;
    total++; if (obs_count !== CNT_W'(start + 1)) $display("[TB] FAIL single_count: got %0d want %0d", obs_count, CNT_W'(start + 1)); else passed++;
  endtask

  task automatic test_streaming();
    int start, valid_cycles, run, max_run, lasts, beats;
    start = words_done;
    valid_cycles = 0; run = 0; max_run = 0; lasts = 0; beats = 0;
    m_ready_i = 1'b1;
    for (int i = 0; i < 8; i++) fifo_q.push_back({$urandom, $urandom});
    for (int c = 0; c < 40; c++) begin
      tick();
      total++; if (obs_rd_en !== exp_rd_en) $display("[TB] FAIL stream_rd_en: got %b want %b", obs_rd_en, exp_rd_en); else passed++;
      total++; if (obs_valid !== exp_valid) $display("[TB] FAIL stream_valid: got %b want %b", obs_valid, exp_valid); else passed++;
      total++; if (obs_last !== exp_last) $display("[TB] FAIL stream_last: got %b want %b", obs_last, exp_last); else passed++;
      total++; if (obs_count !== exp_count) $display("[TB] FAIL stream_count: got %0d want %0d", obs_count, exp_count); else passed++;
      if (exp_valid) begin
        total++; if (obs_data !== exp_data) $display("[TB] FAIL stream_data: got %h want %h", obs_data, exp_data); else passed++;
      end
      if (obs_valid) begin
        valid_cycles++; run++; beats++;
        if (run > max_run) max_run = run;
        if (obs_last) begin
          lasts++;
          total++; if ((beats % RATIO) !== 0) $display("[TB] FAIL stream_last_pos: got beat %0d want multiple of %0d", beats, RATIO); else passed++;
        end
      end else begin
        run = 0;
      end
    end
    total++; if (max_run !== 32) $display("[TB] FAIL stream_run: got %0d want 32", max_run); else passed++;
    total++; if (valid_cycles !== 32) $display("[TB] FAIL stream_valid_cycles: got %0d want 32", valid_cycles); else passed++;
    total++; if (lasts !== 8) $display("[TB] FAIL stream_lasts: got %0d want 8", lasts); else passed++;
    total++; if (obs_count !== CNT_W'(start + 8)) $display("[TB] FAIL stream_final_count: got %0d want %0d", obs_count, CNT_W'(start + 8)); else passed++;
  endtask

  task automatic test_backpressure();
    int start, hs, guard;
    logic [OUT_W-1:0] held;
    start = words_done;
    hs = 0;
    m_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) fifo_q.push_back({$urandom, $urandom});
    for (int c = 0; c < 20 && hs < 1; c++) begin
      tick();
      total++; if (obs_valid !== exp_valid) $display("[TB] FAIL bp_pre_valid: got %b want %b", obs_valid, exp_valid); else passed++;
      if (obs_valid && m_ready_i) hs++;
    end
    total++; if (hs !== 1) $display("[TB] FAIL bp_first_beat: got %0d want 1", hs); else passed++;
    // stall while the second beat of the first word is presented
    m_ready_i = 1'b0;
    held = '0;
    for (int c = 0; c < 5; c++) begin
      tick();
      if (c == 0) held = obs_data;
      total++; if (obs_valid !== 1'b1) $display("[TB] FAIL bp_stall_valid: got %b want 1", obs_valid); else passed++;
      total++; if (obs_rd_en !== 1'b0) $display("[TB] FAIL bp_stall_rd_en: got %b want 0", obs_rd_en); else passed++;
      total++; if (obs_data !== exp_data) $display("[TB] FAIL bp_stall_data: got %h want %h", obs_data, exp_data); else passed++;
      total++; if (obs_data !== held) $display("[TB] FAIL bp_stall_stable: got %h want %h", obs_data, held); else passed++;
      total++; if (obs_last !== 1'b0) $display("[TB] FAIL bp_stall_last: got %b want 0", obs_last); else passed++;
    end
    m_ready_i = 1'b1;
    guard = 0;
    while ((fifo_q.size() != 0 || beat_q.size() != 0 || pop_last != 0) && guard < 40) begin
      tick();
      guard++;
      total++; if (obs_rd_en !== exp_rd_en) $display("[TB] FAIL bp_rd_en: got %b want %b", obs_rd_en, exp_rd_en); else passed++;
      total++; if (obs_valid !== exp_valid) $display("[TB] FAIL bp_valid: got %b want %b", obs_valid, exp_valid); else passed++;
      total++; if (obs_last !== exp_last) $display("[TB] FAIL bp_last: got %b want %b", obs_last, exp_last); else passed++;
      if (exp_valid) begin
        total++; if (obs_data !== exp_data) $display("[TB] FAIL bp_data: got %h want %h", obs_data, exp_data); else passed++;
      end
    end
    total++; if (guard >= 40) $display("[TB] FAIL bp_drain_timeout: got %0d cycles want < 40", guard); else passed++;
    tick();
    total++; if (obs_count !== CNT_W'(start + 4)) $display("[TB] FAIL bp_count: got %0d want %0d", obs_count, CNT_W'(start + 4)); else passed++;
  endtask

  task automatic test_empty_boundary();
    int start, guard;
    start = words_done;
    // permanently empty
    force_empty = 1'b1;
    m_ready_i = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      total++; if (obs_rd_en !== 1'b0) $display("[TB] FAIL empty_rd_en: got %b want 0", obs_rd_en); else passed++;
      total++; if (obs_valid !== 1'b0) $display("[TB] FAIL empty_valid: got %b want 0", obs_valid); else passed++;
    end
    // empty flag toggling every cycle with random ready
    for (int i = 0; i < 10; i++) fifo_q.push_back({$urandom, $urandom});
    guard = 0;
    while ((fifo_q.size() != 0 || beat_q.size() != 0 || pop_last != 0) && guard < 400) begin
      force_empty = ~force_empty;
      m_ready_i = 1'($urandom_range(0, 1));
      tick();
      guard++;
      total++; if (obs_rd_en !== exp_rd_en) $display("[TB] FAIL toggle_rd_en: got %b want %b", obs_rd_en, exp_rd_en); else passed++;
      total++; if (obs_valid !== exp_valid) $display("[TB] FAIL toggle_valid: got %b want %b", obs_valid, exp_valid); else passed++;
      total++; if (obs_last !== exp_last) $display("[TB] FAIL toggle_last: got %b want %b", obs_last, exp_last); else passed++;
      total++; if (obs_count !== exp_count) $display("[TB] FAIL toggle_count: got %0d want %0d", obs_count, exp_count); else passed++;
      if (exp_valid) begin
        total++; if (obs_data !== exp_data) $display("[TB] FAIL toggle_data: got %h want %h", obs_data, exp_data); else passed++;
      end
    end
    force_empty = 1'b0;
    m_ready_i = 1'b1;
    total++; if (guard >= 400) $display("[TB] FAIL toggle_timeout: got %0d cycles want < 400", guard); else passed++;
    total++; if (words_done - start !== 10) $display("[TB] FAIL toggle_words: got %0d want 10", words_done - start); else passed++;
  endtask

  task automatic test_counter_wrap();
    logic [CNT_W-1:0] seen[$];
    logic prev_last_hs;
    int guard;
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    m_ready_i = 1'b1;
    for (int i = 0; i < 17; i++) fifo_q.push_back({$urandom, $urandom});
    prev_last_hs = 1'b0;
    guard = 0;
    while ((fifo_q.size() != 0 || beat_q.size() != 0 || pop_last != 0 || prev_last_hs) && guard < 120) begin
      tick();
      guard++;
      if (prev_last_hs) seen.push_back(obs_count);
      prev_last_hs = obs_valid && m_ready_i && obs_last;
      total++; if (obs_count !== exp_count) $display("[TB] FAIL wrap_count: got %0d want %0d", obs_count, exp_count); else passed++;
      total++; if (obs_valid !== exp_valid) $display("[TB] FAIL wrap_valid: got %b want %b", obs_valid, exp_valid); else passed++;
      if (exp_valid) begin
        total++; if (obs_data !== exp_data) $display("[TB] FAIL wrap_data: got %h want %h", obs_data, exp_data); else passed++;
      end
    end
    total++; if (guard >= 120) $display("[TB] FAIL wrap_timeout: got %0d cycles want < 120", guard); else passed++;
    total++; if (seen.size() !== 17) $display("[TB] FAIL wrap_words: got %0d want 17", seen.size()); else passed++;
    if (seen.size() == 17) begin
      total++; if (seen[14] !== 4'd15) $display("[TB] FAIL wrap_15: got %0d want 15", seen[14]); else passed++;
      total++; if (seen[15] !== 4'd0) $display("[TB] FAIL wrap_0: got %0d want 0", seen[15]); else passed++;
      total++; if (seen[16] !== 4'd1) $display("[TB] FAIL wrap_1: got %0d want 1", seen[16]); else passed++;
    end
  endtask

  initial begin
    rst_i        = 1'b1;
    m_ready_i    = 1'b0;
    fifo_data_i  = '0;
    fifo_empty_i = 1'b1;
    @(negedge clk_i);
    test_reset();
    test_single_word();
    test_streaming();
    test_backpressure();
    test_empty_boundary();
    test_counter_wrap();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
